// File: rtl/noc_link_pipe_monitor.sv
// Per-endpoint link stage: fixed-delay flit and credit register pipes with endpoint-view credit tracking.
// Flit path: LINK_STAGES cycles; credit path: CREDIT_STAGES cycles; no backpressure, errors are sticky flags.
module noc_link_pipe_monitor #(
    parameter int NE            = 16,
    parameter int V             = 4,
    parameter int B             = 4,
    parameter int Fpay          = 32,
    parameter int LINK_STAGES   = 2,
    parameter int CREDIT_STAGES = 2,
    parameter int CNTw          = 16,
    localparam int Fw           = 2 + V + Fpay
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NE*Fw-1:0]     flit_in_all,
    input  logic [NE-1:0]        flit_in_wr_all,
    output logic [NE*Fw-1:0]     flit_out_all,
    output logic [NE-1:0]        flit_out_wr_all,
    input  logic [NE*V-1:0]      credit_in_all,
    output logic [NE*V-1:0]      credit_out_all,
    output logic [NE*V-1:0]      credit_avail_all,
    output logic [NE-1:0]        err_ovf_all,
    output logic [NE-1:0]        err_unf_all,
    input  logic                 err_clr,
    output logic [NE*CNTw-1:0]   pck_cnt_all
);
    localparam int CW = $clog2(B + 1);
    localparam logic [CW-1:0] BCNT = CW'(B);

    logic [NE*V-1:0] ovf_set;
    logic [NE*V-1:0] unf_set;

    // Flit pipe: data stages only load when their valid input is set, so idle cycles don't toggle wide regs.
    generate
        if (LINK_STAGES == 0) begin : g_flit_comb
            assign flit_out_all    = flit_in_all;
            assign flit_out_wr_all = flit_in_wr_all;
        end else begin : g_flit_pipe
            logic [NE*Fw-1:0] fd [LINK_STAGES];
            logic [NE-1:0]    fv [LINK_STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < LINK_STAGES; s++) begin
                        fd[s] <= '0;
                        fv[s] <= '0;
                    end
                end else begin
                    fv[0] <= flit_in_wr_all;
                    for (int e = 0; e < NE; e++) begin
                        if (flit_in_wr_all[e]) fd[0][e*Fw +: Fw] <= flit_in_all[e*Fw +: Fw];
                    end
                    for (int s = 1; s < LINK_STAGES; s++) begin
                        fv[s] <= fv[s-1];
                        for (int e = 0; e < NE; e++) begin
                            if (fv[s-1][e]) fd[s][e*Fw +: Fw] <= fd[s-1][e*Fw +: Fw];
                        end
                    end
                end
            end

            assign flit_out_all    = fd[LINK_STAGES-1];
            assign flit_out_wr_all = fv[LINK_STAGES-1];
        end

        if (CREDIT_STAGES == 0) begin : g_cred_comb
            assign credit_out_all = credit_in_all;
        end else begin : g_cred_pipe
            logic [NE*V-1:0] cd [CREDIT_STAGES];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < CREDIT_STAGES; s++) cd[s] <= '0;
                end else begin
                    cd[0] <= credit_in_all;
                    for (int s = 1; s < CREDIT_STAGES; s++) cd[s] <= cd[s-1];
                end
            end

            assign credit_out_all = cd[CREDIT_STAGES-1];
        end
    endgenerate

    generate
        for (genvar e = 0; e < NE; e++) begin : g_ep
            logic            err_ovf_q;
            logic            err_unf_q;
            logic [CNTw-1:0] pck_q;

            // Counter tracks credits as the endpoint sees them: the delayed credit return, not the raw one.
            for (genvar v = 0; v < V; v++) begin : g_vc
                logic [CW-1:0] cnt;
                logic          avail_q;
                logic          dec;
                logic          inc;

                assign dec = flit_in_wr_all[e] & flit_in_all[e*Fw + Fpay + v];
                assign inc = credit_out_all[e*V + v];
                assign ovf_set[e*V + v] = dec & ~inc & (cnt == '0);
                assign unf_set[e*V + v] = inc & ~dec & (cnt == BCNT);

                always_ff @(posedge clk) begin
                    if (reset) begin
                        cnt     <= BCNT;
                        avail_q <= 1'b1;
                    end else begin
                        avail_q <= (cnt != '0);
                        if (dec && !inc && cnt != '0)
                            cnt <= cnt - CW'(1);
                        else if (inc && !dec && cnt != BCNT)
                            cnt <= cnt + CW'(1);
                    end
                end

                assign credit_avail_all[e*V + v] = avail_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    err_ovf_q <= 1'b0;
                    err_unf_q <= 1'b0;
                    pck_q     <= '0;
                end else begin
                    if (err_clr) begin
                        err_ovf_q <= 1'b0;
                        err_unf_q <= 1'b0;
                    end else begin
                        if (|ovf_set[e*V +: V]) err_ovf_q <= 1'b1;
                        if (|unf_set[e*V +: V]) err_unf_q <= 1'b1;
                    end
                    if (flit_in_wr_all[e] && flit_in_all[e*Fw + Fw - 2])
                        pck_q <= pck_q + CNTw'(1);
                end
            end

            assign err_ovf_all[e]              = err_ovf_q;
            assign err_unf_all[e]              = err_unf_q;
            assign pck_cnt_all[e*CNTw +: CNTw] = pck_q;
        end
    endgenerate
endmodule
